// File: rtl/acq_sequencer.sv
// Pulse-echo frame sequencer: tx pulse, blanking delay, ADC warm-up, sample capture, holdoff.
// Optional auto-repeat start source is enabled by defining ACQ_AUTO_REPEAT_EN.
module acq_sequencer #(
  parameter int CNT_WIDTH = 16,
  parameter int PULSE_W   = 20,
  parameter int WARMUP    = 8,
  parameter int HOLDOFF   = 64
) (
  input  logic                 i_clk_100m,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CNT_WIDTH-1:0] i_delay,
  input  logic [CNT_WIDTH-1:0] i_recv_count,
  input  logic                 i_sample_vld,
`ifdef ACQ_AUTO_REPEAT_EN
  input  logic                 i_auto,
  input  logic [31:0]          i_period,
`endif
  output logic                 o_tx_pulse,
  output logic                 o_ad_open,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_aborted,
  output logic [CNT_WIDTH-1:0] o_sample_idx,
  output logic [15:0]          o_frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_DELAY, S_WARM, S_CAPTURE, S_HOLD
  } state_t;

  localparam logic [CNT_WIDTH-1:0] PULSE_LAST = CNT_WIDTH'(PULSE_W - 1);
  localparam logic [CNT_WIDTH-1:0] WARM_LAST  = CNT_WIDTH'(WARMUP - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(HOLDOFF - 1);
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

  state_t               state, state_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic [CNT_WIDTH-1:0] delay_q, delay_nx;
  logic [CNT_WIDTH-1:0] recv_q, recv_nx;
  logic [CNT_WIDTH-1:0] idx_nx, idx_inc;
  logic [15:0]          frame_nx;
  logic                 done_nx, aborted_nx;
  logic                 active;
  logic                 start_req;

`ifdef ACQ_AUTO_REPEAT_EN
  // Period counter restarts on every PULSE entry so PULSE entries land i_period apart.
  logic [31:0] period_cnt;
  logic        auto_pend;
  logic        auto_hit;
  logic        enter_pulse;

  assign enter_pulse = (state == S_IDLE) && (state_nx == S_PULSE);
  assign auto_hit    = i_auto && (period_cnt == i_period - 32'd1);
  assign start_req   = i_start | (i_auto & auto_pend) | auto_hit;

  always_ff @(posedge i_clk_100m) begin
    if (i_rst) begin
      period_cnt <= '0;
      auto_pend  <= 1'b0;
    end else begin
      if (enter_pulse)
        period_cnt <= '0;
      else if (period_cnt != '1)
        period_cnt <= period_cnt + 32'd1;
      if (enter_pulse || !i_auto)
        auto_pend <= 1'b0;
      else if (auto_hit)
        auto_pend <= 1'b1;
    end
  end
`else
  assign start_req = i_start;
`endif

  assign idx_inc = o_sample_idx + ONE;
  assign active  = (state == S_PULSE) || (state == S_DELAY) ||
                   (state == S_WARM)  || (state == S_CAPTURE);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + ONE;
    delay_nx   = delay_q;
    recv_nx    = recv_q;
    idx_nx     = o_sample_idx;
    frame_nx   = o_frame_cnt;
    done_nx    = 1'b0;
    aborted_nx = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (start_req && !i_abort) begin
          state_nx = S_PULSE;
          delay_nx = i_delay;
          recv_nx  = i_recv_count;
          idx_nx   = '0;
        end
      end
      S_PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_nx   = '0;
          state_nx = (delay_q == '0) ? S_WARM : S_DELAY;
        end
      end
      S_DELAY: begin
        if (cnt == delay_q - ONE) begin
          cnt_nx   = '0;
          state_nx = S_WARM;
        end
      end
      S_WARM: begin
        if (cnt == WARM_LAST) begin
          cnt_nx   = '0;
          state_nx = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        cnt_nx = '0;
        if (recv_q == '0) begin
          state_nx = S_HOLD;
          done_nx  = 1'b1;
          frame_nx = o_frame_cnt + 16'd1;
        end else if (i_sample_vld) begin
          idx_nx = idx_inc;
          if (idx_inc == recv_q) begin
            state_nx = S_HOLD;
            done_nx  = 1'b1;
            frame_nx = o_frame_cnt + 16'd1;
          end
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase

    // Abort wins over any completion or sample in the same cycle.
    if (active && i_abort) begin
      state_nx   = S_HOLD;
      cnt_nx     = '0;
      idx_nx     = o_sample_idx;
      frame_nx   = o_frame_cnt;
      done_nx    = 1'b0;
      aborted_nx = 1'b1;
    end
  end

  always_ff @(posedge i_clk_100m) begin
    if (i_rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      delay_q      <= '0;
      recv_q       <= '0;
      o_tx_pulse   <= 1'b0;
      o_ad_open    <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_aborted    <= 1'b0;
      o_sample_idx <= '0;
      o_frame_cnt  <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      delay_q      <= delay_nx;
      recv_q       <= recv_nx;
      o_tx_pulse   <= (state_nx == S_PULSE);
      o_ad_open    <= (state_nx == S_WARM) || (state_nx == S_CAPTURE);
      o_busy       <= (state_nx != S_IDLE);
      o_done       <= done_nx;
      o_aborted    <= aborted_nx;
      o_sample_idx <= idx_nx;
      o_frame_cnt  <= frame_nx;
    end
  end

endmodule
